// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding modes and IEEE-754 single-precision field layout.
package fpu_pkg;

  localparam int unsigned F32_EXP_W = 8;
  localparam int unsigned F32_MAN_W = 23;
  localparam int unsigned F32_BIAS  = 127;

  typedef enum logic [1:0] {
    RM_RTZ = 2'b00,
    RM_RNE = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } round_mode_t;

  typedef struct packed {
    logic                 sign;
    logic [F32_EXP_W-1:0] exp;
    logic [F32_MAN_W-1:0] man;
  } f32_t;

endpackage

// File: rtl/ftoi_round.sv
// Round / negate / saturate stage of the float-to-int converter (purely combinational).
module ftoi_round
  import fpu_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic             i_sign,
  input  round_mode_t      i_rm,
  input  logic             i_nan,
  input  logic             i_presat,
  input  logic [OUT_W-1:0] i_mag,
  input  logic             i_g,
  input  logic             i_st,
  output logic [OUT_W-1:0] o_y_c,
  output logic             o_invalid_c,
  output logic             o_inexact_c
);

  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  logic             w_inc;
  logic [OUT_W:0]   w_m;
  logic [OUT_W-1:0] w_m_lo;
  logic             w_ovf;
  logic             w_sat;

  // Rounding increment from sign, LSB, guard and sticky
  always_comb begin
    w_inc = 1'b0;
    case (i_rm)
      RM_RTZ:  w_inc = 1'b0;
      RM_RNE:  w_inc = i_g & (i_st | i_mag[0]);
      RM_RDN:  w_inc = i_sign & (i_g | i_st);
      RM_RUP:  w_inc = ~i_sign & (i_g | i_st);
      default: w_inc = 1'b0;
    endcase
  end

  // Magnitude with one spare bit, range check against the signed limits
  always_comb begin
    w_m    = {1'b0, i_mag} + (OUT_W+1)'(w_inc);
    w_m_lo = w_m[OUT_W-1:0];
    // -2^(OUT_W-1) is representable, so negative overflow needs a bit beyond the MSB
    if (i_sign) begin
      w_ovf = w_m[OUT_W] | (w_m[OUT_W-1] & (|w_m[OUT_W-2:0]));
    end else begin
      w_ovf = w_m[OUT_W] | w_m[OUT_W-1];
    end
    w_sat = i_presat | w_ovf;
  end

  // Final value and flags; NaN always saturates to the positive limit
  always_comb begin
    o_y_c       = '0;
    o_invalid_c = w_sat;
    o_inexact_c = ~w_sat & (i_g | i_st);
    if (i_nan) begin
      o_y_c = MAX_POS;
    end else if (w_sat) begin
      o_y_c = i_sign ? MIN_NEG : MAX_POS;
    end else begin
      o_y_c = i_sign ? (~w_m_lo + OUT_W'(1)) : w_m_lo;
    end
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage IEEE-754 single to signed-integer converter with valid/ready backpressure.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [1:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic             invalid,
  output logic             inexact
);

  localparam int unsigned SIG_W  = F32_MAN_W + 1;
  localparam int unsigned FULL_W = OUT_W + SIG_W;
  localparam int unsigned SH_W   = $clog2(OUT_W);
  localparam logic signed [9:0] E_BIAS = 10'(F32_BIAS);
  localparam logic signed [9:0] E_SAT  = 10'(OUT_W);
  localparam logic signed [9:0] E_TOP  = 10'(OUT_W - 1);

  f32_t                w_x;
  logic signed [9:0]   w_e_unb;
  logic [SIG_W-1:0]    w_sig;
  logic [SH_W-1:0]     w_sh;
  logic [FULL_W-1:0]   w_full;
  logic [OUT_W-1:0]    w_mag;
  logic                w_g;
  logic                w_st;
  logic                w_presat;
  logic                w_nan;
  logic                w_s2_en;

  logic                r_s1_valid;
  logic                r_s1_sign;
  round_mode_t         r_s1_rm;
  logic                r_s1_nan;
  logic                r_s1_presat;
  logic [OUT_W-1:0]    r_s1_mag;
  logic                r_s1_g;
  logic                r_s1_st;

  logic                r_out_valid;
  logic [OUT_W-1:0]    r_y;
  logic                r_invalid;
  logic                r_inexact;

  logic [OUT_W-1:0]    w_y_c;
  logic                w_invalid_c;
  logic                w_inexact_c;

  assign w_x      = x;
  assign w_e_unb  = $signed({2'b00, w_x.exp}) - E_BIAS;
  assign w_sig    = {1'b1, w_x.man};
  assign w_sh     = w_e_unb[SH_W-1:0];
  assign w_s2_en  = ~r_out_valid | out_ready;
  assign in_ready = ~r_s1_valid | w_s2_en;

  // S1 decode/align: classify, then shift the significand so the binary point sits at bit 23
  always_comb begin
    w_mag    = '0;
    w_g      = 1'b0;
    w_st     = 1'b0;
    w_presat = 1'b0;
    w_nan    = 1'b0;
    w_full   = FULL_W'(w_sig) << w_sh;
    if (w_x.exp == '0) begin
      // zero and subnormals flush to an exact zero
    end else if (w_x.exp == '1) begin
      w_presat = 1'b1;
      w_nan    = |w_x.man;
    end else if (w_e_unb >= E_SAT) begin
      w_presat = 1'b1;
    end else if (w_e_unb == E_TOP && !w_x.sign) begin
      // positive magnitude already >= 2^(OUT_W-1); negatives go through so -2^(OUT_W-1) survives
      w_presat = 1'b1;
    end else if (w_e_unb < 0) begin
      w_g  = (w_e_unb == -10'sd1);
      w_st = (w_e_unb == -10'sd1) ? (|w_x.man) : 1'b1;
    end else begin
      w_mag = w_full[F32_MAN_W +: OUT_W];
      w_g   = w_full[F32_MAN_W-1];
      w_st  = |w_full[F32_MAN_W-2:0];
    end
  end

  // S1 register: loads whenever the stage is free or draining into S2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_rm     <= RM_RTZ;
      r_s1_nan    <= 1'b0;
      r_s1_presat <= 1'b0;
      r_s1_mag    <= '0;
      r_s1_g      <= 1'b0;
      r_s1_st     <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign   <= w_x.sign;
        r_s1_rm     <= round_mode_t'(rm);
        r_s1_nan    <= w_nan;
        r_s1_presat <= w_presat;
        r_s1_mag    <= w_mag;
        r_s1_g      <= w_g;
        r_s1_st     <= w_st;
      end
    end
  end

  ftoi_round #(
    .OUT_W (OUT_W)
  ) u_round (
    .i_sign      (r_s1_sign),
    .i_rm        (r_s1_rm),
    .i_nan       (r_s1_nan),
    .i_presat    (r_s1_presat),
    .i_mag       (r_s1_mag),
    .i_g         (r_s1_g),
    .i_st        (r_s1_st),
    .o_y_c       (w_y_c),
    .o_invalid_c (w_invalid_c),
    .o_inexact_c (w_inexact_c)
  );

  // S2 output register: holds its result while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_invalid   <= 1'b0;
      r_inexact   <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y       <= w_y_c;
        r_invalid <= w_invalid_c;
        r_inexact <= w_inexact_c;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign invalid   = r_invalid;
  assign inexact   = r_inexact;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: 32-bit and 16-bit instances driven in lockstep against a value-level model.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x = '0;
  logic [1:0]  rm = '0;

  logic        in_ready_a, out_valid_a, inv_a, inex_a;
  logic [31:0] y_a;
  logic        in_ready_b, out_valid_b, inv_b, inex_b;
  logic [15:0] y_b;

  int n_checks = 0;
  int n_fail   = 0;

  // {x, rm, y32, invalid, inexact}
  logic [67:0] dv [21] = '{
    {32'h40200000, 2'd0, 32'h00000002, 1'b0, 1'b1},
    {32'h40200000, 2'd1, 32'h00000002, 1'b0, 1'b1},
    {32'h40200000, 2'd2, 32'h00000002, 1'b0, 1'b1},
    {32'h40200000, 2'd3, 32'h00000003, 1'b0, 1'b1},
    {32'hC0200000, 2'd0, 32'hFFFFFFFE, 1'b0, 1'b1},
    {32'hC0200000, 2'd1, 32'hFFFFFFFE, 1'b0, 1'b1},
    {32'hC0200000, 2'd2, 32'hFFFFFFFD, 1'b0, 1'b1},
    {32'hC0200000, 2'd3, 32'hFFFFFFFE, 1'b0, 1'b1},
    {32'h40600000, 2'd1, 32'h00000004, 1'b0, 1'b1},
    {32'h4F000000, 2'd0, 32'h7FFFFFFF, 1'b1, 1'b0},
    {32'hCF000000, 2'd0, 32'h80000000, 1'b0, 1'b0},
    {32'h7FC00000, 2'd1, 32'h7FFFFFFF, 1'b1, 1'b0},
    {32'hFF800000, 2'd0, 32'h80000000, 1'b1, 1'b0},
    {32'h3E99999A, 2'd0, 32'h00000000, 1'b0, 1'b1},
    {32'h3E99999A, 2'd3, 32'h00000001, 1'b0, 1'b1},
    {32'h00000001, 2'd3, 32'h00000000, 1'b0, 1'b0},
    {32'h80000000, 2'd1, 32'h00000000, 1'b0, 1'b0},
    {32'h3F000000, 2'd1, 32'h00000000, 1'b0, 1'b1},
    {32'h47000000, 2'd0, 32'h00008000, 1'b0, 1'b0},
    {32'hCF000001, 2'd0, 32'h80000000, 1'b1, 1'b0},
    {32'h7F800000, 2'd2, 32'h7FFFFFFF, 1'b1, 1'b0}
  };

  logic [31:0] bb_x [8] = '{32'h40200000, 32'hC0200000, 32'h3E99999A, 32'h4F000000,
                            32'h40600000, 32'hCF000000, 32'h7FC00000, 32'h46FFFE00};

  ftoi_pipe #(.OUT_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .x(x), .rm(rm),
    .out_valid(out_valid_a), .out_ready(out_ready), .y(y_a), .invalid(inv_a), .inexact(inex_a)
  );

  ftoi_pipe #(.OUT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .x(x), .rm(rm),
    .out_valid(out_valid_b), .out_ready(out_ready), .y(y_b), .invalid(inv_b), .inexact(inex_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Exact value-level conversion: returns {invalid, inexact, y (64-bit two's complement)}
  function automatic logic [65:0] ref_conv(input logic [31:0] xv, input logic [1:0] rmv, input int w);
    bit neg, up;
    int e;
    longint unsigned sig, den, q, rem, m, maxp, minm;
    logic [63:0] ymax, ymin;
    neg  = xv[31];
    e    = int'(xv[30:23]) - 127;
    maxp = (64'd1 << (w - 1)) - 64'd1;
    minm = 64'd1 << (w - 1);
    ymax = maxp;
    ymin = -minm;
    if (xv[30:23] == 8'hFF) return (xv[22:0] != 0 || !neg) ? {2'b10, ymax} : {2'b10, ymin};
    if (xv[30:23] == 8'h00) return '0;
    if (e > 62) return neg ? {2'b10, ymin} : {2'b10, ymax};
    sig = 64'h800000 | 64'(xv[22:0]);
    if (e >= 23) begin
      q = sig << (e - 23); rem = 0; den = 1;
    end else if (e >= -30) begin
      den = 64'd1 << (23 - e); q = sig / den; rem = sig % den;
    end else begin
      q = 0; rem = 1; den = 64'd1 << 60;
    end
    case (rmv)
      2'd1:    up = (2 * rem > den) || (2 * rem == den && q[0]);
      2'd2:    up = neg && (rem != 0);
      2'd3:    up = !neg && (rem != 0);
      default: up = 1'b0;
    endcase
    m = q + 64'(up);
    if (!neg && m > maxp) return {2'b10, ymax};
    if (neg && m > minm) return {2'b10, ymin};
    return {1'b0, rem != 0, neg ? -m : m};
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k == 1) v[30:23] = 8'hFF;
    else if (k == 2) v[30:23] = 8'h00;
    else if (k == 3) v[22:0] = '0;
    else if (k >= 4) v[30:23] = 8'($urandom_range(118, 160));
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid_a, inv_a, inex_a, y_a} !== 35'd0 || {out_valid_b, inv_b, inex_b, y_b} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state: got32 %h got16 %h, want 0", {out_valid_a, inv_a, inex_a, y_a},
               {out_valid_b, inv_b, inex_b, y_b});
    end
    n_checks++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b/%b want 1", in_ready_a, in_ready_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [33:0] e32;
    logic [65:0] r16;
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      x   = dv[i][67:36];
      rm  = dv[i][35:34];
      e32 = {dv[i][1], dv[i][0], dv[i][33:2]};
      r16 = ref_conv(dv[i][67:36], dv[i][35:34], 16);
      in_valid = 1'b1;
      #1;
      n_checks++;
      if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
        n_fail++;
        $display("FAIL dir_in_ready[%0d]: got %b/%b want 1", i, in_ready_a, in_ready_b);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_latency_early[%0d]: out_valid %b/%b want 0", i, out_valid_a, out_valid_b);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid_a !== 1'b1 || out_valid_b !== 1'b1) begin
        n_fail++;
        $display("FAIL dir_latency[%0d]: out_valid %b/%b want 1", i, out_valid_a, out_valid_b);
      end
      n_checks++;
      if ({inv_a, inex_a, y_a} !== e32) begin
        n_fail++;
        $display("FAIL dir32[%0d] x=%h rm=%0d: got {inv,inex,y}=%h want %h", i, x, rm, {inv_a, inex_a, y_a}, e32);
      end
      n_checks++;
      if ({inv_b, inex_b, y_b} !== {r16[65:64], r16[15:0]}) begin
        n_fail++;
        $display("FAIL dir16[%0d] x=%h rm=%0d: got {inv,inex,y}=%h want %h", i, x, rm, {inv_b, inex_b, y_b},
                 {r16[65:64], r16[15:0]});
      end
      @(posedge clk); #1;
    end
  endtask

  // Streams operands through both instances; rnd=0 uses bb_x with out_ready pattern 1,0,0
  task automatic test_stream(input string name, input int n_ops, input bit rnd);
    logic [65:0] q32[$];
    logic [65:0] q16[$];
    logic [65:0] e;
    logic [31:0] cx;
    logic [1:0]  crm;
    logic [33:0] h32;
    logic [17:0] h16;
    logic        exp_rdy;
    bit          have, held;
    int          sent, got, cyc;
    have = 0; held = 0; sent = 0; got = 0; cyc = 0;
    cx = '0; crm = '0; h32 = '0; h16 = '0;
    while (got < n_ops && cyc < 40 * n_ops) begin
      if (held) begin
        n_checks++;
        if (out_valid_a !== 1'b1 || {inv_a, inex_a, y_a} !== h32 ||
            out_valid_b !== 1'b1 || {inv_b, inex_b, y_b} !== h16) begin
          n_fail++;
          $display("FAIL %s_hold cyc=%0d: got %b %h / %b %h want 1 %h / 1 %h", name, cyc, out_valid_a,
                   {inv_a, inex_a, y_a}, out_valid_b, {inv_b, inex_b, y_b}, h32, h16);
        end
      end
      if (!have && sent < n_ops) begin
        cx   = rnd ? rand_x() : bb_x[sent];
        crm  = rnd ? 2'($urandom_range(0, 3)) : 2'(sent % 4);
        have = 1;
      end
      in_valid  = have && (!rnd || ($urandom_range(0, 3) != 0));
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'(cyc % 3 == 0);
      x  = cx;
      rm = crm;
      #1;
      exp_rdy = !(q32.size() == 2 && !out_ready);
      n_checks++;
      if (in_ready_a !== exp_rdy || in_ready_b !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s_in_ready cyc=%0d: got %b/%b want %b", name, cyc, in_ready_a, in_ready_b, exp_rdy);
      end
      if (out_valid_a === 1'b1 && out_ready) begin
        n_checks++;
        if (q32.size() == 0) begin
          n_fail++;
          $display("FAIL %s_spurious32 cyc=%0d: got y=%h want no result", name, cyc, y_a);
        end else begin
          e = q32.pop_front();
          if ({inv_a, inex_a, y_a} !== {e[65:64], e[31:0]}) begin
            n_fail++;
            $display("FAIL %s_data32 cyc=%0d: got %h want %h", name, cyc, {inv_a, inex_a, y_a}, {e[65:64], e[31:0]});
          end
        end
        got++;
      end
      if (out_valid_b === 1'b1 && out_ready) begin
        n_checks++;
        if (q16.size() == 0) begin
          n_fail++;
          $display("FAIL %s_spurious16 cyc=%0d: got y=%h want no result", name, cyc, y_b);
        end else begin
          e = q16.pop_front();
          if ({inv_b, inex_b, y_b} !== {e[65:64], e[15:0]}) begin
            n_fail++;
            $display("FAIL %s_data16 cyc=%0d: got %h want %h", name, cyc, {inv_b, inex_b, y_b}, {e[65:64], e[15:0]});
          end
        end
      end
      held = (out_valid_a === 1'b1) && !out_ready;
      h32  = {inv_a, inex_a, y_a};
      h16  = {inv_b, inex_b, y_b};
      if (in_valid && in_ready_a === 1'b1) begin
        q32.push_back(ref_conv(cx, crm, 32));
        q16.push_back(ref_conv(cx, crm, 16));
        sent++;
        have = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != n_ops || q32.size() != 0 || q16.size() != 0) begin
      n_fail++;
      $display("FAIL %s_complete: got %0d results (%0d/%0d left) want %0d", name, got, q32.size(), q16.size(), n_ops);
    end
  endtask

  task automatic test_back_to_back();
    test_stream("b2b", 8, 1'b0);
  endtask

  task automatic test_random();
    test_stream("rand", 300, 1'b1);
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x = 32'h40200000; rm = 2'd0;
    @(posedge clk); #1;
    x = 32'h41000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid_a !== 1'b1 || out_valid_b !== 1'b1 || in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full: out_valid %b/%b in_ready %b/%b want 1/1 0/0", out_valid_a, out_valid_b,
               in_ready_a, in_ready_b);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after_rst: out_valid %b/%b in_ready %b/%b want 0/0 1/1", out_valid_a, out_valid_b,
               in_ready_a, in_ready_b);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_result[%0d]: out_valid %b/%b want 0", i, out_valid_a, out_valid_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
